// File: rtl/regfile_scoreboard.sv
// Decode-stage register file: two combinational read ports, one writeback
// port, optional hardwired zero register, write-to-read bypass, and a
// per-register busy scoreboard with a running count of pending producers.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_addr,
  output logic [ADDR_W:0]   pending_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [ADDR_W:0]   pending_cnt_q;
  logic [ADDR_W:0]   pending_cnt_d;
  logic              wr_ok;
  logic              alloc_ok;
  logic              cnt_inc;
  logic              cnt_dec;

  // Register 0 is inert (reads zero, never written, never busy) when enabled.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Resolve one read port: zero register, then bypass, then stored state.
  // Returns {busy, data}.
  function automatic logic [DATA_W:0] read_port(
    input logic [ADDR_W-1:0] a,
    input logic              w_en,
    input logic [ADDR_W-1:0] w_addr,
    input logic [DATA_W-1:0] w_data,
    input logic [DATA_W-1:0] stored,
    input logic              busy
  );
    if (is_zero(a)) return '0;
    if ((BYPASS != 0) && w_en && (w_addr == a)) return {1'b0, w_data};
    return {busy, stored};
  endfunction

  // Next-state for data, busy bits and the pending count.
  always_comb begin
    wr_ok    = wr_en && !is_zero(wr_addr);
    alloc_ok = alloc_en && !is_zero(alloc_addr);
    regs_d   = regs_q;
    busy_d   = busy_q;
    if (wr_ok) begin
      regs_d[wr_addr] = wr_data;
      busy_d[wr_addr] = 1'b0;
    end
    // Alloc applied after the write so a same-edge new producer wins.
    if (alloc_ok) busy_d[alloc_addr] = 1'b1;
    // Count only real 0->1 and 1->0 transitions so the count tracks popcount.
    cnt_inc = alloc_ok && !busy_q[alloc_addr];
    cnt_dec = wr_ok && busy_q[wr_addr] && !(alloc_ok && (alloc_addr == wr_addr));
    pending_cnt_d = pending_cnt_q + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
  end

  // State registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q        <= '0;
      pending_cnt_q <= '0;
    end else begin
      regs_q        <= regs_d;
      busy_q        <= busy_d;
      pending_cnt_q <= pending_cnt_d;
    end
  end

  // Combinational read ports.
  always_comb begin
    {rd_busy_a, rd_data_a} = read_port(rd_addr_a, wr_en, wr_addr, wr_data,
                                       regs_q[rd_addr_a], busy_q[rd_addr_a]);
    {rd_busy_b, rd_data_b} = read_port(rd_addr_b, wr_en, wr_addr, wr_data,
                                       regs_q[rd_addr_b], busy_q[rd_addr_b]);
  end

  assign pending_cnt = pending_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: stimulus pushes expected values,
// a monitor process pops and compares them when a sample is requested.
module tb_regfile_scoreboard;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam int K_DA  = 0;
  localparam int K_DB  = 1;
  localparam int K_BA  = 2;
  localparam int K_BB  = 3;
  localparam int K_CNT = 4;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_busy_a;
  logic              rd_busy_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              alloc_en;
  logic [ADDR_W-1:0] alloc_addr;
  logic [ADDR_W:0]   pending_cnt;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  event smp_ev;
  int   total = 0;
  int   bad   = 0;

  regfile_scoreboard #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .pending_cnt(pending_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Monitor: on each sample request, pop and compare every queued expectation.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(smp_ev);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e.kind)
          K_DA:    act = rd_data_a;
          K_DB:    act = rd_data_b;
          K_BA:    act = 32'(rd_busy_a);
          K_BB:    act = 32'(rd_busy_b);
          default: act = 32'(pending_cnt);
        endcase
        total++;
        if (act !== e.val) begin
          bad++;
          $display("FAIL %s: act=0x%0h exp=0x%0h (t=%0t)", e.name, act, e.val, $time);
        end
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] v);
    exp_t e;
    e.name = nm;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic fire();
    -> smp_ev;
    #2;
  endtask

  task automatic idle_in();
    wr_en = 1'b0; alloc_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    rd_addr_a = '0; rd_addr_b = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0;
    #1 rst_n = 1'b0;

    // Reset state on several addresses
    @(negedge clk);
    rd_addr_a = 5'd0; rd_addr_b = 5'd7;
    chk("rst_da0", K_DA, 0); chk("rst_db7", K_DB, 0);
    chk("rst_ba0", K_BA, 0); chk("rst_bb7", K_BB, 0); chk("rst_cnt", K_CNT, 0);
    fire();
    rd_addr_a = 5'd31;
    chk("rst_da31", K_DA, 0); chk("rst_ba31", K_BA, 0);
    fire();
    @(negedge clk);
    rst_n = 1'b1;

    // Write r5, bypass in the write cycle, then stored on both ports
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr_a = 5'd5; rd_addr_b = 5'd7;
    chk("byp_da5", K_DA, 32'hDEADBEEF); chk("byp_ba5", K_BA, 0); chk("byp_db7", K_DB, 0);
    fire();
    @(negedge clk);
    idle_in(); rd_addr_a = 5'd5; rd_addr_b = 5'd5;
    chk("st_da5", K_DA, 32'hDEADBEEF); chk("st_db5", K_DB, 32'hDEADBEEF);
    fire();

    // Zero register ignores write and alloc
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; alloc_en = 1'b1; alloc_addr = 5'd0;
    rd_addr_a = 5'd0;
    chk("z_byp_da0", K_DA, 0); chk("z_byp_ba0", K_BA, 0);
    fire();
    @(negedge clk);
    idle_in();
    chk("z_da0", K_DA, 0); chk("z_ba0", K_BA, 0); chk("z_cnt", K_CNT, 0);
    fire();

    // Alloc r3 then r4
    alloc_en = 1'b1; alloc_addr = 5'd3;
    @(negedge clk);
    chk("a3_cnt", K_CNT, 1);
    fire();
    alloc_addr = 5'd4;
    @(negedge clk);
    alloc_en = 1'b0; rd_addr_a = 5'd3; rd_addr_b = 5'd4;
    chk("a4_cnt", K_CNT, 2); chk("a_ba3", K_BA, 1); chk("a_bb4", K_BB, 1);
    fire();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
    chk("w3_da", K_DA, 32'h55); chk("w3_ba", K_BA, 0); chk("w3_bb4", K_BB, 1);
    chk("w3_cnt_pre", K_CNT, 2);
    fire();
    @(negedge clk);
    idle_in();
    chk("w3_cnt", K_CNT, 1); chk("w3_da_st", K_DA, 32'h55); chk("w3_ba_st", K_BA, 0);
    fire();

    // Same-edge write and alloc of non-busy r9
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99; alloc_en = 1'b1; alloc_addr = 5'd9;
    rd_addr_a = 5'd9;
    chk("wa9_byp_da", K_DA, 32'h99); chk("wa9_byp_ba", K_BA, 0);
    fire();
    @(negedge clk);
    idle_in();
    chk("wa9_da", K_DA, 32'h99); chk("wa9_ba", K_BA, 1); chk("wa9_cnt", K_CNT, 2);
    fire();
    alloc_en = 1'b1; alloc_addr = 5'd9;
    @(negedge clk);
    idle_in();
    chk("re9_cnt", K_CNT, 2); chk("re9_ba", K_BA, 1);
    fire();

    // Same-edge write and alloc of already-busy r4
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44; alloc_en = 1'b1; alloc_addr = 5'd4;
    @(negedge clk);
    idle_in(); rd_addr_b = 5'd4;
    chk("wa4_cnt", K_CNT, 2); chk("wa4_bb", K_BB, 1); chk("wa4_db", K_DB, 32'h44);
    fire();

    // Alloc r10 while writing busy r9: +1 and -1 on the same edge
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h909; alloc_en = 1'b1; alloc_addr = 5'd10;
    @(negedge clk);
    idle_in(); rd_addr_a = 5'd9; rd_addr_b = 5'd10;
    chk("mix_cnt", K_CNT, 2); chk("mix_ba9", K_BA, 0); chk("mix_bb10", K_BB, 1);
    chk("mix_da9", K_DA, 32'h909);
    fire();

    // Fill the scoreboard: r1..r31
    for (int i = 1; i < 32; i++) begin
      alloc_en = 1'b1; alloc_addr = 5'(i);
      @(negedge clk);
    end
    alloc_en = 1'b1; alloc_addr = 5'd0;
    @(negedge clk);
    idle_in(); rd_addr_a = 5'd5; rd_addr_b = 5'd4;
    chk("full_cnt", K_CNT, 31); chk("full_ba5", K_BA, 1); chk("full_da5", K_DA, 32'hDEADBEEF);
    chk("full_db4", K_DB, 32'h44);
    fire();

    // Asynchronous reset mid-cycle
    rst_n = 1'b0;
    chk("ar_cnt", K_CNT, 0); chk("ar_ba", K_BA, 0); chk("ar_bb", K_BB, 0);
    chk("ar_da", K_DA, 0); chk("ar_db", K_DB, 0);
    fire();

    // Bypass during reset forwards but does not store
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66; rd_addr_a = 5'd6;
    chk("rbyp_da6", K_DA, 32'h66);
    fire();
    @(negedge clk);
    idle_in();
    chk("rbyp_st6", K_DA, 0);
    fire();
    rst_n = 1'b1;

    // Write to r2 after release does not underflow
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h22;
    @(negedge clk);
    idle_in(); rd_addr_a = 5'd2; rd_addr_b = 5'd6;
    chk("post_cnt", K_CNT, 0); chk("post_da2", K_DA, 32'h22); chk("post_ba2", K_BA, 0);
    chk("post_db6", K_DB, 0);
    fire();

    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: act=%0d exp=0 leftover", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised successor to the processor's register bank: a 2-read/1-write register file with asynchronous reset, optional hardwired zero register, write-to-read bypass and a per-register busy scoreboard. It sits in the decode stage of the pipelined core. Decode reads operands and hazard flags here, marks destination registers busy at issue, and the writeback stage clears them when it writes the result.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W registers
- ZERO_REG, 1, when 1, register 0 always reads 0, ignores writes and is never busy
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching read ports

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rd_addr_a  in  ADDR_W  read port A address
- rd_addr_b  in  ADDR_W  read port B address
- rd_data_a  out  DATA_W  read port A data (combinational)
- rd_data_b  out  DATA_W  read port B data (combinational)
- rd_busy_a  out  1  register at rd_addr_a has a pending write
- rd_busy_b  out  1  register at rd_addr_b has a pending write
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback address
- wr_data  in  DATA_W  writeback data
- alloc_en  in  1  issue strobe; marks alloc_addr busy
- alloc_addr  in  ADDR_W  destination register being issued
- pending_cnt  out  ADDR_W+1  number of registers currently busy

## Operation
- Storage: 2**ADDR_W x DATA_W registers, plus a busy bit per register, plus pending_cnt.
- Write: on a rising edge with wr_en=1, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0. If ZERO_REG=1 and wr_addr=0, nothing happens.
- Alloc: on a rising edge with alloc_en=1, busy[alloc_addr] <= 1. If ZERO_REG=1 and alloc_addr=0, nothing happens.
- Same edge, wr_en and alloc_en to the same address: the data is written and busy ends at 1, because the new producer wins. pending_cnt is unchanged when the register was already busy.
- Alloc of a register that is already busy: busy stays 1 and pending_cnt does not change. The scoreboard tracks only the latest producer.
- Write to a register that is not busy: data is written and pending_cnt does not change.
- Reads (combinational, per port p):
  - ZERO_REG=1 and addr=0: data=0, busy=0.
  - Else, BYPASS=1 and wr_en=1 and wr_addr=addr: data=wr_data, busy=0.
  - Else: data=reg[addr], busy=busy[addr].
- Alloc does not affect the read outputs until the following edge.
- pending_cnt always equals the popcount of busy. It is updated at each edge by +1, -1 or 0 from the net busy transitions. It never wraps: its maximum is 2**ADDR_W - ZERO_REG.

## Timing
- Reset (rst_n=0, asynchronous, takes effect immediately): all registers 0, all busy bits 0, pending_cnt=0.
  - While reset is held, rd_data_*=0 and rd_busy_*=0. Bypass is still active, so a wr_en presented during reset can be forwarded combinationally but is not stored.
- Reset mid-operation discards all pending scoreboard state. Writes arriving after reset release are stored normally and do not decrement pending_cnt below 0.
- Write and alloc latency: 1 cycle; state is visible after the next rising edge.
- Read latency: 0 cycles; output is combinational from the addresses, wr_* and state.
- Bypass makes write-then-read in the same cycle return the new data with zero latency.
- Both read ports are fully independent and may address the same register.

## Test plan
- Reset, then read addresses 0, 7 and 31 -> rd_data=0, rd_busy=0, pending_cnt=0.
- Write 0xDEADBEEF to r5; next cycle read r5 on both ports -> 0xDEADBEEF on A and B. With the same cycle's wr_en to r5 and rd_addr_a=5 (BYPASS=1) -> 0xDEADBEEF combinationally.
- Write 0x1234 to r0 with ZERO_REG=1; alloc r0 -> reads of r0 = 0, rd_busy=0, pending_cnt stays 0.
- Alloc r3 then r4 on consecutive cycles -> pending_cnt 1, then 2, with rd_busy for r3 and r4 = 1.
  - Write r3 = 0x55 -> in the write cycle, rd_busy_a(r3)=0 and rd_data_a=0x55; after the edge, pending_cnt=1.
- Same-edge alloc and write of r9 (r9 not busy) -> r9 data written, busy=1, pending_cnt +1. Alloc r9 again -> pending_cnt unchanged.
- Alloc r1..r31 (pending_cnt=31), then assert rst_n=0 mid-cycle -> pending_cnt, busy and data clear immediately without waiting for a clock edge.
  - After release, write r2 -> pending_cnt remains 0.
